// File: rtl/mdio_master_ext_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mdio_master_ext_if                                          |
// | Description : Request/response and MDIO pad signals of mdio_master_ext.   |
// |               The master modport is the MDIO master's view. The slave    |
// |               modport is the view of the register-access controller      |
// |               and pad side.                                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface mdio_master_ext_if;
  // Request side
  logic        start;
  logic        clause45;
  logic [1:0]  op;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] data_in;
  logic        preamble_suppress;
  // Response side
  logic        busy;
  logic        done;
  logic [15:0] data_out;
  logic        rd_err;
  // MDIO pad side
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i;

  modport master (
    input  start, clause45, op, phy_addr, reg_addr, data_in, preamble_suppress,
    input  mdio_i,
    output busy, done, data_out, rd_err,
    output mdc, mdio_o, mdio_oe
  );

  modport slave (
    output start, clause45, op, phy_addr, reg_addr, data_in, preamble_suppress,
    output mdio_i,
    input  busy, done, data_out, rd_err,
    input  mdc, mdio_o, mdio_oe
  );
endinterface
`default_nettype wire

// File: rtl/mdio_master_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mdio_master_ext                                            |
// | Description : MDIO management master for Clause 22 and Clause 45 frames. |
// |               It has a programmable MDC divider and optional preamble     |
// |               suppression. The MDIO pin is split into o/oe/i, and a read  |
// |               turnaround error is flagged. Every output is registered.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mdio_master_ext #(
  parameter int CLK_DIV      = 10,    // clk cycles per MDC period, even, >= 4
  parameter int PREAMBLE_LEN = 32,    // number of preamble '1' bits
  parameter bit SUPPORT_C45  = 1'b1   // 0 forces Clause 22 framing
) (
  input  wire               clk,
  input  wire               reset,
  mdio_master_ext_if.master mgmt_if
);

  localparam int DIV_W = $clog2(CLK_DIV);

  // Divider positions within one bit: mdc is low for the first half of the bit
  // and high for the second half. mdio_i is captured on the edge that raises mdc.
  localparam logic [DIV_W-1:0] c_DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] c_DIV_HALF   = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] c_DIV_SAMPLE = DIV_W'(CLK_DIV / 2 - 1);

  // Index of the last bit of each frame section
  localparam logic [6:0] c_PRE_LAST  = 7'(PREAMBLE_LEN - 1);
  localparam logic [6:0] c_HDR_LAST  = 7'd13;
  localparam logic [6:0] c_TA_LAST   = 7'd1;
  localparam logic [6:0] c_DATA_LAST = 7'd15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Sequencing state
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       bit_q, bit_d;

  // Fields latched at acceptance: {ST, OP, PHYAD, REGAD}, write data, direction
  logic [13:0]      hdr_q, hdr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             rd_q, rd_d;

  // Read capture: data shift register and the sampled second TA bit
  logic [15:0]      cap_q, cap_d;
  logic             ta_q, ta_d;

  // Registered outputs
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      data_out_q, data_out_d;
  logic             rd_err_q, rd_err_d;
  logic             mdc_q, mdc_d;
  logic             mdio_o_q, mdio_o_d;
  logic             mdio_oe_q, mdio_oe_d;

  // Request decode
  logic             w_c45;
  logic             w_req_read;
  logic [13:0]      w_req_hdr;
  state_t           w_req_state;

  // Per-section bookkeeping
  logic [6:0]       w_bit_last;
  state_t           w_state_next;
  logic             w_bit_end;
  logic             w_sample_edge;

  // Clause 45 framing only exists when the build supports it
  assign w_c45       = mgmt_if.clause45 & SUPPORT_C45;
  assign w_req_read  = w_c45 ? mgmt_if.op[1] : (mgmt_if.op == 2'b10);
  // ST is 00 for Clause 45 and 01 for Clause 22
  assign w_req_hdr   = {1'b0, ~w_c45, mgmt_if.op, mgmt_if.phy_addr, mgmt_if.reg_addr};
  assign w_req_state = (mgmt_if.preamble_suppress || (PREAMBLE_LEN == 0)) ? S_HDR : S_PRE;

  assign w_bit_end     = (div_q == c_DIV_LAST);
  assign w_sample_edge = (div_q == c_DIV_SAMPLE);

  // Length of the current section and the section that follows it
  always_comb begin
    w_bit_last   = c_DATA_LAST;
    w_state_next = S_DONE;
    case (state_q)
      S_PRE: begin
        w_bit_last   = c_PRE_LAST;
        w_state_next = S_HDR;
      end
      S_HDR: begin
        w_bit_last   = c_HDR_LAST;
        w_state_next = S_TA;
      end
      S_TA: begin
        w_bit_last   = c_TA_LAST;
        w_state_next = S_DATA;
      end
      default: begin
        w_bit_last   = c_DATA_LAST;
        w_state_next = S_DONE;
      end
    endcase
  end

  // Next-state logic: acceptance, bit/divider stepping, read capture, completion
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    hdr_d      = hdr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    cap_d      = cap_q;
    ta_d       = ta_q;
    data_out_d = data_out_q;
    rd_err_d   = rd_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A request in the DONE cycle starts the next frame at once, so no idle bit is inserted
        if (mgmt_if.start) begin
          state_d = w_req_state;
          div_d   = '0;
          bit_d   = '0;
          hdr_d   = w_req_hdr;
          wdata_d = mgmt_if.data_in;
          rd_d    = w_req_read;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (rd_q && w_sample_edge) begin
          if ((state_q == S_TA) && (bit_q == c_TA_LAST)) begin
            ta_d = mgmt_if.mdio_i;
          end
          if (state_q == S_DATA) begin
            cap_d = {cap_q[14:0], mgmt_if.mdio_i};
          end
        end
        if (w_bit_end) begin
          div_d = '0;
          if (bit_q == w_bit_last) begin
            bit_d   = '0;
            state_d = w_state_next;
          end else begin
            bit_d = bit_q + 7'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase

    // Results are published on entry to DONE. rd_err is cleared for frames that are not reads.
    if (state_d == S_DONE) begin
      rd_err_d = rd_q & ta_q;
      if (rd_q) begin
        data_out_d = cap_q;
      end
    end
  end

  // Pad and status values for the coming cycle. They are derived from the next state so the outputs stay registered.
  always_comb begin
    busy_d    = state_d inside {S_PRE, S_HDR, S_TA, S_DATA};
    done_d    = (state_d == S_DONE);
    mdc_d     = busy_d && (div_d >= c_DIV_HALF);
    mdio_o_d  = 1'b1;
    mdio_oe_d = 1'b0;
    case (state_d)
      S_PRE: begin
        mdio_oe_d = 1'b1;
      end
      S_HDR: begin
        mdio_oe_d = 1'b1;
        mdio_o_d  = hdr_d[4'd13 - bit_d[3:0]];
      end
      S_TA: begin
        // On a read the PHY owns the turnaround. On a write the master drives 1 then 0.
        if (!rd_d) begin
          mdio_oe_d = 1'b1;
          mdio_o_d  = (bit_d == 7'd0);
        end
      end
      S_DATA: begin
        if (!rd_d) begin
          mdio_oe_d = 1'b1;
          mdio_o_d  = wdata_d[4'd15 - bit_d[3:0]];
        end
      end
      default: begin
        mdio_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      hdr_q      <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      cap_q      <= '0;
      ta_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      rd_err_q   <= 1'b0;
      mdc_q      <= 1'b0;
      mdio_o_q   <= 1'b1;
      mdio_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      hdr_q      <= hdr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      cap_q      <= cap_d;
      ta_q       <= ta_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      rd_err_q   <= rd_err_d;
      mdc_q      <= mdc_d;
      mdio_o_q   <= mdio_o_d;
      mdio_oe_q  <= mdio_oe_d;
    end
  end

  assign mgmt_if.busy     = busy_q;
  assign mgmt_if.done     = done_q;
  assign mgmt_if.data_out = data_out_q;
  assign mgmt_if.rd_err   = rd_err_q;
  assign mgmt_if.mdc      = mdc_q;
  assign mgmt_if.mdio_o   = mdio_o_q;
  assign mgmt_if.mdio_oe  = mdio_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_master_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mdio_master_ext                                         |
// | Description : Directed, table-driven bench for mdio_master_ext that      |
// |               includes a small PHY responder model.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mdio_master_ext;

  typedef struct {
    logic        c45;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] din;
    logic        sup;
    logic        rd;     // frame is a read, so the PHY answers
    logic        ta2;    // value the PHY puts on the second TA bit
    logic [15:0] pdata;  // data the PHY returns
    logic [13:0] hdr;    // expected {ST, OP, PHYAD, REGAD}
    int          lat;    // expected cycle of done, counting the start cycle as 0
    logic [15:0] dout;   // expected data_out at done
    logic        err;    // expected rd_err at done
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mdio_master_ext_if m ();

  mdio_master_ext #(
    .CLK_DIV      (10),
    .PREAMBLE_LEN (32),
    .SUPPORT_C45  (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mgmt_if (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic c45, logic [1:0] op, logic [4:0] phy, logic [4:0] rg,
                               logic [15:0] din, logic sup, logic rd, logic ta2,
                               logic [15:0] pdata, logic [13:0] hdr, int lat,
                               logic [15:0] dout, logic err);
    vec_t v;
    v.c45 = c45; v.op = op; v.phy = phy; v.rg = rg; v.din = din; v.sup = sup;
    v.rd = rd; v.ta2 = ta2; v.pdata = pdata; v.hdr = hdr; v.lat = lat;
    v.dout = dout; v.err = err;
    return v;
  endfunction

  // PHY responder: the value on mdio_i during frame bit idx
  function automatic logic phy_bit(input vec_t v, input int idx);
    int p;
    p = v.sup ? 0 : 32;
    if (!v.rd) return 1'b1;
    if (idx == p + 15) return v.ta2;
    if ((idx >= p + 16) && (idx < p + 32)) return v.pdata[15 - (idx - p - 16)];
    return 1'b1;
  endfunction

  // Called #1 after an edge. It issues the request, follows the frame and stops in the done cycle.
  task automatic run_frame(input string tag, input vec_t v, input int poke_cyc);
    int          cyc;
    int          nb;
    int          p;
    logic        prev_mdc;
    logic        o_bits[128];
    logic        oe_bits[128];
    logic [13:0] hdr;
    logic [17:0] tail;
    logic        ok;
    p = v.sup ? 0 : 32;
    m.clause45 = v.c45; m.op = v.op; m.phy_addr = v.phy; m.reg_addr = v.rg;
    m.data_in = v.din; m.preamble_suppress = v.sup; m.start = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
    cyc = 1; nb = 0; prev_mdc = 1'b0;
    m.mdio_i = phy_bit(v, 0);
    chk({tag, "_busy_start"}, m.busy, 1);
    while ((m.done !== 1'b1) && (cyc <= v.lat + 20)) begin
      if (cyc == poke_cyc) begin
        m.start = 1'b1; m.clause45 = ~v.c45; m.op = ~v.op; m.phy_addr = ~v.phy;
        m.reg_addr = ~v.rg; m.data_in = ~v.din; m.preamble_suppress = ~v.sup;
      end else begin
        m.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (m.mdc && !prev_mdc && nb < 128) begin
        o_bits[nb]  = m.mdio_o;
        oe_bits[nb] = m.mdio_oe;
        nb++;
      end
      if (!m.mdc && prev_mdc) m.mdio_i = phy_bit(v, nb);
      prev_mdc = m.mdc;
    end
    m.start = 1'b0;
    chk({tag, "_latency"}, cyc, v.lat);
    chk({tag, "_nbits"}, nb, p + 32);
    if (p > 0) begin
      ok = 1'b1;
      for (int i = 0; i < p; i++) if (o_bits[i] !== 1'b1 || oe_bits[i] !== 1'b1) ok = 1'b0;
      chk({tag, "_preamble"}, ok, 1);
    end
    hdr = '0; ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      hdr = {hdr[12:0], o_bits[p + i]};
      if (oe_bits[p + i] !== 1'b1) ok = 1'b0;
    end
    chk({tag, "_header"}, hdr, v.hdr);
    chk({tag, "_header_oe"}, ok, 1);
    tail = '0; ok = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tail = {tail[16:0], o_bits[p + 14 + i]};
      if (oe_bits[p + 14 + i] !== !v.rd) ok = 1'b0;
    end
    chk({tag, "_ta_data_oe"}, ok, 1);
    if (!v.rd) chk({tag, "_ta_data_bits"}, tail, {2'b10, v.din});
    chk({tag, "_done"}, m.done, 1);
    chk({tag, "_busy_at_done"}, m.busy, 0);
    chk({tag, "_data_out"}, m.data_out, v.dout);
    chk({tag, "_rd_err"}, m.rd_err, v.err);
  endtask

  // Leaves the done cycle and confirms the bus stays quiet with no new frame
  task automatic idle_check(input string tag, input int ncyc);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (m.busy !== 1'b0 || m.done !== 1'b0 || m.mdc !== 1'b0 || m.mdio_oe !== 1'b0) ok = 1'b0;
    end
    chk({tag, "_quiet"}, ok, 1);
  endtask

  vec_t vecs[8];
  vec_t vx;

  initial begin
    checks = 0;
    errors = 0;
    //                c45  op     phy     reg     din       sup  rd  ta2  pdata     hdr                  lat  dout      err
    vecs[0] = mkv(1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b0, 1'b0, 1'b1, 16'h0000, 14'b01010000100000, 641, 16'h0000, 1'b0);
    vecs[1] = mkv(1'b0, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0141, 14'b01100001100010, 641, 16'h0141, 1'b0);
    vecs[2] = mkv(1'b1, 2'b00, 5'h02, 5'h01, 16'h0007, 1'b0, 1'b0, 1'b1, 16'h0000, 14'b00000001000001, 641, 16'h0141, 1'b0);
    vecs[3] = mkv(1'b1, 2'b11, 5'h02, 5'h01, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hBEEF, 14'b00110001000001, 641, 16'hBEEF, 1'b0);
    vecs[4] = mkv(1'b0, 2'b01, 5'h1F, 5'h1F, 16'hA5A5, 1'b1, 1'b0, 1'b1, 16'h0000, 14'b01011111111111, 321, 16'hBEEF, 1'b0);
    vecs[5] = mkv(1'b0, 2'b10, 5'h04, 5'h01, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFF, 14'b01100010000001, 641, 16'hFFFF, 1'b1);
    vecs[6] = mkv(1'b0, 2'b01, 5'h00, 5'h04, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 14'b01010000000100, 641, 16'hFFFF, 1'b0);
    vecs[7] = mkv(1'b1, 2'b10, 5'h05, 5'h03, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 14'b00100010100011, 321, 16'h1234, 1'b0);

    m.start = 1'b0; m.clause45 = 1'b0; m.op = 2'b00; m.phy_addr = '0; m.reg_addr = '0;
    m.data_in = '0; m.preamble_suppress = 1'b0; m.mdio_i = 1'b1;

    // Reset values
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", m.busy, 0);
    chk("rst_done", m.done, 0);
    chk("rst_rd_err", m.rd_err, 0);
    chk("rst_data_out", m.data_out, 16'h0000);
    chk("rst_mdc", m.mdc, 0);
    chk("rst_mdio_o", m.mdio_o, 1);
    chk("rst_mdio_oe", m.mdio_oe, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // The table runs back to back: each request is issued in the previous frame's done cycle
    for (int i = 0; i < 8; i++) run_frame($sformatf("v%0d", i), vecs[i], -1);
    idle_check("after_table", 30);

    // A start during a frame must not corrupt it or queue a second frame
    vx = mkv(1'b0, 2'b01, 5'h0A, 5'h05, 16'hC3C3, 1'b0, 1'b0, 1'b1, 16'h0000,
             14'b01010101000101, 641, 16'h1234, 1'b0);
    run_frame("poke", vx, 100);
    idle_check("poke", 700);

    // Reset in the middle of the DATA phase of a read
    m.clause45 = 1'b0; m.op = 2'b10; m.phy_addr = 5'h03; m.reg_addr = 5'h02;
    m.preamble_suppress = 1'b0; m.mdio_i = 1'b1; m.start = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
    repeat (520) @(posedge clk);
    #1;
    chk("mid_in_data_oe", m.mdio_oe, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_mdc", m.mdc, 0);
    chk("mid_rst_oe", m.mdio_oe, 0);
    chk("mid_rst_busy", m.busy, 0);
    chk("mid_rst_done", m.done, 0);
    chk("mid_rst_data_out", m.data_out, 16'h0000);
    idle_check("mid_rst", 40);
    run_frame("after_rst", vecs[0], -1);
    idle_check("after_rst", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
